// File: rtl/aib_mac_chk_pkg.sv
// aib_mac_chk_pkg: shared state encoding and PRBS31 word-parallel predictor
package aib_mac_chk_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, SEEK = 2'd1, LOCKED = 2'd2} chk_state_t;
  localparam int TAP_A = 31;
  localparam int TAP_B = 28;
  localparam int MAXW = 256;
  // Stream bits of the current word sit at s[0 +: w]; the next word is grown above them.
  function automatic logic [MAXW-1:0] prbs31_next(input logic [MAXW-1:0] cur, input int w);
    logic [2*MAXW-1:0] s;
    s = {{MAXW{1'b0}}, cur};
    for (int i = 0; i < w; i++)
      s[w+i] = s[w+i-TAP_A] ^ s[w+i-TAP_B];
    return MAXW'(s >> w);
  endfunction
endpackage

// File: rtl/aib_mac_prbs_cnt.sv
// aib_mac_prbs_cnt: saturating up-counter with synchronous clear that wins over increment
module aib_mac_prbs_cnt #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] cnt
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (inc && !(&cnt)) cnt <= cnt + 1'b1;
endmodule

// File: rtl/aib_mac_prbs_chk.sv
// aib_mac_prbs_chk: self-synchronising PRBS31 receive checker with lock, error and word counters
module aib_mac_prbs_chk
  import aib_mac_chk_pkg::*;
#(
  parameter int DWIDTH   = 40,
  parameter int LOCK_CNT = 8,
  parameter int LOSS_CNT = 4,
  parameter int ERRW     = 16,
  parameter int CNTW     = 32
) (
  input  logic                rd_clk,
  input  logic                rd_rstn,
  input  logic                chk_en,
  input  logic                data_vld,
  input  logic [2*DWIDTH-1:0] data_out,
  input  logic                clr_cnt,
  output logic                lock,
  output logic                err_flag,
  output logic [ERRW-1:0]     err_cnt,
  output logic [CNTW-1:0]     word_cnt,
  output logic [1:0]          chk_state
);
  localparam int W = 2 * DWIDTH;
  chk_state_t state, state_nxt;
  logic [W-1:0] pred, pred_d, data_nxt, pred_adv;
  logic [7:0] run_cnt, run_d, miss_cnt, miss_d;
  logic seeded, seeded_d, err_d, mis;
  assign data_nxt = W'(prbs31_next(MAXW'(data_out), W));
  assign pred_adv = W'(prbs31_next(MAXW'(pred), W));
  assign mis = |(data_out ^ pred);
  always_comb begin
    state_nxt = state;
    pred_d = pred;
    run_d = run_cnt;
    miss_d = miss_cnt;
    seeded_d = seeded;
    err_d = 1'b0;
    if (!chk_en) begin
      state_nxt = IDLE;
      seeded_d = 1'b0;
      run_d = '0;
      miss_d = '0;
    end else begin
      case (state)
        IDLE: begin
          state_nxt = SEEK;
          run_d = '0;
          miss_d = '0;
          if (data_vld) begin
            pred_d = data_nxt;
            seeded_d = 1'b1;
          end
        end
        // SEEK always reseeds from received data; an all-zero word can never build a run
        SEEK: if (data_vld) begin
          pred_d = data_nxt;
          seeded_d = 1'b1;
          run_d = (seeded && !mis && |data_out) ? run_cnt + 8'd1 : 8'd0;
          if (run_d == 8'(LOCK_CNT)) begin
            state_nxt = LOCKED;
            miss_d = '0;
          end
        end
        // LOCKED free-runs the predictor so a bad word cannot corrupt later predictions
        LOCKED: if (data_vld) begin
          pred_d = pred_adv;
          err_d = mis;
          miss_d = mis ? miss_cnt + 8'd1 : 8'd0;
          if (miss_d == 8'(LOSS_CNT)) begin
            state_nxt = SEEK;
            pred_d = data_nxt;
            seeded_d = 1'b1;
            run_d = '0;
            miss_d = '0;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end
  always_ff @(posedge rd_clk or negedge rd_rstn)
    if (!rd_rstn) begin
      state <= IDLE;
      pred <= '0;
      run_cnt <= '0;
      miss_cnt <= '0;
      seeded <= 1'b0;
      err_flag <= 1'b0;
    end else begin
      state <= state_nxt;
      pred <= pred_d;
      run_cnt <= run_d;
      miss_cnt <= miss_d;
      seeded <= seeded_d;
      err_flag <= err_d;
    end
  assign lock = (state == LOCKED);
  assign chk_state = state;
  aib_mac_prbs_cnt #(.WIDTH(ERRW)) u_err_cnt (
    .clk(rd_clk), .rst_n(rd_rstn), .clr(clr_cnt), .inc(err_d), .cnt(err_cnt)
  );
  aib_mac_prbs_cnt #(.WIDTH(CNTW)) u_word_cnt (
    .clk(rd_clk), .rst_n(rd_rstn), .clr(clr_cnt),
    .inc(chk_en && data_vld && state == LOCKED), .cnt(word_cnt)
  );
endmodule

// File: tb/tb_aib_mac_prbs_chk.sv
// tb_aib_mac_prbs_chk: table-driven check of lock, errors, gaps, saturation, reset and zero data
module tb_aib_mac_prbs_chk;
  logic rd_clk = 1'b0, rd_rstn = 1'b0, chk_en = 1'b0, data_vld = 1'b0, clr_cnt = 1'b0;
  logic [79:0] data_out = '0;
  logic lock, err_flag, lock4, err_flag4;
  logic [15:0] err_cnt;
  logic [3:0] err_cnt4;
  logic [31:0] word_cnt, word_cnt4;
  logic [1:0] chk_state, chk_state4;
  int checks = 0, errors = 0;
  logic [30:0] hist = 31'h1;

  aib_mac_prbs_chk u_dut (
    .rd_clk(rd_clk), .rd_rstn(rd_rstn), .chk_en(chk_en), .data_vld(data_vld),
    .data_out(data_out), .clr_cnt(clr_cnt), .lock(lock), .err_flag(err_flag),
    .err_cnt(err_cnt), .word_cnt(word_cnt), .chk_state(chk_state)
  );
  aib_mac_prbs_chk #(.ERRW(4)) u_dut4 (
    .rd_clk(rd_clk), .rd_rstn(rd_rstn), .chk_en(chk_en), .data_vld(data_vld),
    .data_out(data_out), .clr_cnt(clr_cnt), .lock(lock4), .err_flag(err_flag4),
    .err_cnt(err_cnt4), .word_cnt(word_cnt4), .chk_state(chk_state4)
  );

  always #5 rd_clk = ~rd_clk;

  // Bit-serial reference generator: hist[j] holds stream bit n-1-j
  task automatic gen_word(output logic [79:0] w);
    logic nb;
    for (int i = 0; i < 80; i++) begin
      nb = hist[30] ^ hist[27];
      w[i] = nb;
      hist = {hist[29:0], nb};
    end
  endtask

  task automatic drive(input bit en, input bit vld, input bit clr, input logic [79:0] mask);
    logic [79:0] w;
    chk_en = en;
    data_vld = vld;
    clr_cnt = clr;
    if (vld) begin
      gen_word(w);
      data_out = w ^ mask;
    end else data_out = ~data_out;
    @(posedge rd_clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    int n; bit en; bit vld; bit clr; logic [79:0] mask;
    bit lock; logic [1:0] st; bit flag; int errs; int words;
  } row_t;

  localparam logic [79:0] M0 = '0;
  localparam logic [79:0] M5 = 80'h20;
  localparam logic [79:0] M79 = {1'b1, 79'h0};

  row_t tbl[16];
  int lock_hits;

  initial begin
    tbl = '{
      '{8,   1, 1, 0, M0,  0, 2'd1, 0, 0, 0},
      '{1,   1, 1, 0, M0,  1, 2'd2, 0, 0, 0},
      '{100, 1, 1, 0, M0,  1, 2'd2, 0, 0, 100},
      '{1,   1, 1, 0, M5,  1, 2'd2, 1, 1, 101},
      '{1,   1, 1, 0, M0,  1, 2'd2, 0, 1, 102},
      '{3,   1, 0, 0, M0,  1, 2'd2, 0, 1, 102},
      '{1,   1, 1, 0, M0,  1, 2'd2, 0, 1, 103},
      '{3,   1, 1, 0, M79, 1, 2'd2, 1, 4, 106},
      '{1,   1, 1, 0, M79, 0, 2'd1, 1, 5, 107},
      '{8,   1, 1, 0, M0,  0, 2'd1, 0, 5, 107},
      '{1,   1, 1, 0, M0,  1, 2'd2, 0, 5, 107},
      '{1,   1, 1, 1, M5,  1, 2'd2, 1, 0, 0},
      '{2,   1, 1, 0, M0,  1, 2'd2, 0, 0, 2},
      '{1,   0, 1, 0, M0,  0, 2'd0, 0, 0, 2},
      '{1,   1, 1, 0, M0,  0, 2'd1, 0, 0, 2},
      '{8,   1, 1, 0, M0,  1, 2'd2, 0, 0, 2}
    };
    repeat (2) @(posedge rd_clk);
    #1;
    check("reset lock", lock, 0);
    check("reset err_flag", err_flag, 0);
    check("reset err_cnt", err_cnt, 0);
    check("reset word_cnt", word_cnt, 0);
    check("reset state", chk_state, 0);
    rd_rstn = 1'b1;
    for (int r = 0; r < 16; r++) begin
      for (int k = 0; k < tbl[r].n; k++) drive(tbl[r].en, tbl[r].vld, tbl[r].clr, tbl[r].mask);
      check($sformatf("row%0d lock", r), lock, tbl[r].lock);
      check($sformatf("row%0d state", r), chk_state, tbl[r].st);
      check($sformatf("row%0d err_flag", r), err_flag, tbl[r].flag);
      check($sformatf("row%0d err_cnt", r), err_cnt, tbl[r].errs);
      check($sformatf("row%0d word_cnt", r), word_cnt, tbl[r].words);
      check($sformatf("row%0d err_cnt4", r), err_cnt4, tbl[r].errs);
    end
    // Isolated errors keep lock while pushing the narrow counter into saturation
    for (int i = 0; i < 18; i++) begin
      drive(1, 1, 0, M5);
      drive(1, 1, 0, M0);
      if (i == 14) begin
        check("sat15 err_cnt4", err_cnt4, 15);
        check("sat15 err_cnt", err_cnt, 15);
      end
    end
    check("sat18 err_cnt4", err_cnt4, 15);
    check("sat18 err_cnt", err_cnt, 18);
    check("sat18 word_cnt", word_cnt, 38);
    check("sat18 lock", lock, 1);
    rd_rstn = 1'b0;
    #1;
    check("async rst lock", lock, 0);
    check("async rst err_cnt", err_cnt, 0);
    check("async rst word_cnt", word_cnt, 0);
    check("async rst state", chk_state, 0);
    check("async rst err_flag", err_flag, 0);
    drive(0, 0, 0, M0);
    rd_rstn = 1'b1;
    chk_en = 1'b1;
    data_vld = 1'b1;
    data_out = '0;
    lock_hits = 0;
    repeat (50) begin
      @(posedge rd_clk);
      #1;
      if (lock) lock_hits++;
    end
    check("zero data lock hits", lock_hits, 0);
    check("zero data state", chk_state, 1);
    check("zero data word_cnt", word_cnt, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
